xadac_issue_stage: RTL and testbench
====================================

Name: xadac_issue_stage

Overview:
- Initiator-side counterpart of the XADAC execute-stage mux. It accepts offloaded vector instructions from the core, reads operands from an internal vector register file (VRF), and checks hazards against a pending-write scoreboard.
- It drives requests into the execute stage, tracks outstanding transactions by ID, and retires responses.
- Retirement writes vd into the VRF and forwards rd to core writeback.

Parameters:
- IdWidth, 4, transaction ID width; the ID table has 2**IdWidth entries.
- XLen, 32, scalar register width.
- VLen, 64, vector register width.
- NoVRegs, 32, number of vector registers; address = instr field, 5 bits.

Ports:
- clk  in  1  clock
- rstn  in  1  async active-low reset
- in_valid  in  1  core offers instruction
- in_ready  out  1  instruction consumed (issued or rejected)
- in_id  in  IdWidth  core transaction ID
- in_instr  in  32  instruction word
- in_rs1  in  XLen  rs1 value
- in_rs2  in  XLen  rs2 value
- req_valid  out  1  request to execute stage
- req_ready  in  1  execute stage takes request
- req_id  out  IdWidth  = in_id
- req_instr  out  32  = in_instr
- req_rs1  out  XLen  = in_rs1
- req_rs2  out  XLen  = in_rs2
- req_vs1  out  VLen  VRF[instr[19:15]]
- req_vs2  out  VLen  VRF[instr[24:20]]
- req_vs3  out  VLen  VRF[instr[11:7]]
- req_rs1_read, req_rs2_read, req_vs1_read, req_vs2_read, req_vs3_read  in  1 each  unit operand usage; combinational from req_instr
- req_rd_clobber  in  1  unit will write rd
- req_vd_clobber  in  1  unit will write vd = instr[11:7]
- req_accept  in  1  instruction recognised by a unit
- resp_valid  in  1  execute stage response
- resp_ready  out  1  response taken
- resp_id  in  IdWidth  response ID
- resp_rd  in  XLen  scalar result
- resp_vd  in  VLen  vector result
- resp_rd_write  in  1  rd valid
- resp_vd_write  in  1  vd valid
- wb_valid  out  1  scalar writeback pulse
- wb_id  out  IdWidth  writeback ID
- wb_rd  out  XLen  writeback data
- illegal  out  1  pulse: instruction rejected (req_accept=0)

Behaviour:
- Reset (async on rstn low): VRF all zero; pend[NoVRegs]=0; ID table valid bits=0; wb_valid=0, wb_id=0, wb_rd=0, illegal=0. Combinational outputs are quiescent because in_valid is ignored.
- Stall condition, evaluated on registered state only (no same-cycle bypass):
  - (vs1_read & pend[vs1]) | (vs2_read & pend[vs2]) | (vs3_read & pend[vs3]) | (vd_clobber & pend[vd]) | tbl_valid[in_id].
- req_valid = in_valid & ~stall; in_ready = req_valid & req_ready.
- Payload is held stable while req_valid=1 and req_ready=0, because the core must hold in_*.
- On issue handshake with req_accept=1:
  - tbl[in_id] <= {valid=1, vd, vd_clobber, rd_clobber}.
  - If vd_clobber, pend[vd] <= 1.
  - If neither clobber is set, no table entry is made; a later response with that ID is dropped.
- On issue handshake with req_accept=0: no state change except illegal <= 1 for one cycle.
- resp_ready = 1 whenever out of reset.
- On response handshake:
  - If tbl_valid[resp_id] & resp_vd_write & tbl_vd_clobber: VRF[tbl_vd] <= resp_vd and pend[tbl_vd] <= 0.
  - If tbl_valid & tbl_vd_clobber & ~resp_vd_write: pend cleared, VRF unchanged.
  - If resp_rd_write: wb_valid <= 1, wb_id <= resp_id, wb_rd <= resp_rd. Registered, so latency is 1 cycle.
  - tbl_valid[resp_id] <= 0.
- Response with tbl_valid[resp_id]=0: only rd writeback occurs; no VRF or pend change.
- Simultaneous issue and retire in the same cycle:
  - Both updates apply.
  - A set and a clear of the same pend bit cannot coincide (WAW stall). If they ever do, set wins.
  - A retire and an issue using the same ID cannot coincide (ID stall). If they ever do, issue wins.
- A hazard cleared by a retire in cycle N unblocks issue in cycle N+1.
- wb_valid and illegal are single-cycle pulses.
- Reset mid-operation drops all outstanding entries and pending bits.

Test Plan:
- Issue vload (vd_clobber=1, vd=3, id=2, accept=1) -> pend[3]=1. Response id=2, vd_write=1, vd=0xA5A5 -> next cycle VRF[3]=0xA5A5, pend[3]=0.
- RAW: vmacc reading vs1=3 while pend[3]=1 -> req_valid=0. Response clears pend in cycle N -> req_valid=1 in N+1, req_vs1=new value.
- WAW and ID reuse: second instruction with vd=3 pending, or with id=2 outstanding -> stalled until retire.
- Unrecognised instruction (accept=0, req_ready=1) -> in_ready=1, illegal pulses 1 cycle, no pend/tbl change.
- Response with rd_write=1, rd=0x1234, id=5 -> wb_valid=1, wb_id=5, wb_rd=0x1234 exactly one cycle later.
- Deassert rstn with 3 outstanding IDs and pend bits set -> all cleared immediately. A previously hazarding instruction issues in the first cycle after reset release.

Source files
------------

// File: rtl/xadac_issue_stage_if.sv
// XADAC issue-to-execute bus: request channel driven by the issue stage,
// operand-usage/accept feedback and response channel driven by the execute stage.
interface xadac_issue_stage_if #(
  parameter int unsigned IdWidth = 4,
  parameter int unsigned XLen    = 32,
  parameter int unsigned VLen    = 64
);
  logic               req_valid;
  logic               req_ready;
  logic [IdWidth-1:0] req_id;
  logic [31:0]        req_instr;
  logic [XLen-1:0]    req_rs1;
  logic [XLen-1:0]    req_rs2;
  logic [VLen-1:0]    req_vs1;
  logic [VLen-1:0]    req_vs2;
  logic [VLen-1:0]    req_vs3;
  logic               req_rs1_read;
  logic               req_rs2_read;
  logic               req_vs1_read;
  logic               req_vs2_read;
  logic               req_vs3_read;
  logic               req_rd_clobber;
  logic               req_vd_clobber;
  logic               req_accept;

  logic               resp_valid;
  logic               resp_ready;
  logic [IdWidth-1:0] resp_id;
  logic [XLen-1:0]    resp_rd;
  logic [VLen-1:0]    resp_vd;
  logic               resp_rd_write;
  logic               resp_vd_write;

  modport master (
    output req_valid, req_id, req_instr, req_rs1, req_rs2, req_vs1, req_vs2, req_vs3,
    input  req_ready, req_rs1_read, req_rs2_read, req_vs1_read, req_vs2_read, req_vs3_read,
    input  req_rd_clobber, req_vd_clobber, req_accept,
    input  resp_valid, resp_id, resp_rd, resp_vd, resp_rd_write, resp_vd_write,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_id, req_instr, req_rs1, req_rs2, req_vs1, req_vs2, req_vs3,
    output req_ready, req_rs1_read, req_rs2_read, req_vs1_read, req_vs2_read, req_vs3_read,
    output req_rd_clobber, req_vd_clobber, req_accept,
    output resp_valid, resp_id, resp_rd, resp_vd, resp_rd_write, resp_vd_write,
    input  resp_ready
  );
endinterface

// File: rtl/xadac_issue_stage.sv
// XADAC issue stage: VRF operand read, pending-write/ID hazard stall, issue to the
// execute stage, and retirement of responses into the VRF and core writeback.
module xadac_issue_stage #(
  parameter int unsigned IdWidth = 4,
  parameter int unsigned XLen    = 32,
  parameter int unsigned VLen    = 64,
  parameter int unsigned NoVRegs = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IdWidth-1:0]  in_id,
  input  logic [31:0]         in_instr,
  input  logic [XLen-1:0]     in_rs1,
  input  logic [XLen-1:0]     in_rs2,
  xadac_issue_stage_if.master bus,
  output logic                wb_valid,
  output logic [IdWidth-1:0]  wb_id,
  output logic [XLen-1:0]     wb_rd,
  output logic                illegal
);

  localparam int unsigned NoIds = 2 ** IdWidth;

  logic [VLen-1:0]    vrf_q [NoVRegs];
  logic [NoVRegs-1:0] pend_q, pend_d;
  logic [NoIds-1:0]   tbl_valid_q, tbl_valid_d;
  logic [NoIds-1:0]   tbl_vdc_q, tbl_vdc_d;
  logic [NoIds-1:0]   tbl_rdc_q, tbl_rdc_d;
  logic [4:0]         tbl_vd_q [NoIds];
  logic [4:0]         tbl_vd_d [NoIds];

  logic               wb_valid_q, wb_valid_d;
  logic [IdWidth-1:0] wb_id_q, wb_id_d;
  logic [XLen-1:0]    wb_rd_q, wb_rd_d;
  logic               illegal_q, illegal_d;

  logic [4:0] vs1, vs2, vd;
  logic       stall, issue_fire, resp_fire, vrf_we;
  logic [4:0] vrf_waddr;

  assign vs1 = in_instr[19:15];
  assign vs2 = in_instr[24:20];
  assign vd  = in_instr[11:7];

  // Hazards look at registered state only; a retire unblocks issue one cycle later.
  assign stall = (bus.req_vs1_read   & pend_q[vs1]) |
                 (bus.req_vs2_read   & pend_q[vs2]) |
                 (bus.req_vs3_read   & pend_q[vd])  |
                 (bus.req_vd_clobber & pend_q[vd])  |
                 tbl_valid_q[in_id];

  assign bus.req_valid  = rstn & in_valid & ~stall;
  assign in_ready       = bus.req_valid & bus.req_ready;
  assign bus.req_id     = in_id;
  assign bus.req_instr  = in_instr;
  assign bus.req_rs1    = in_rs1;
  assign bus.req_rs2    = in_rs2;
  assign bus.req_vs1    = vrf_q[vs1];
  assign bus.req_vs2    = vrf_q[vs2];
  assign bus.req_vs3    = vrf_q[vd];
  assign bus.resp_ready = rstn;

  assign issue_fire = in_ready;
  assign resp_fire  = bus.resp_valid & bus.resp_ready;

  // Retire is applied first so that an overlapping issue update wins.
  always_comb begin
    pend_d      = pend_q;
    tbl_valid_d = tbl_valid_q;
    tbl_vdc_d   = tbl_vdc_q;
    tbl_rdc_d   = tbl_rdc_q;
    tbl_vd_d    = tbl_vd_q;
    vrf_we      = 1'b0;
    vrf_waddr   = tbl_vd_q[bus.resp_id];
    wb_valid_d  = 1'b0;
    wb_id_d     = wb_id_q;
    wb_rd_d     = wb_rd_q;
    illegal_d   = issue_fire & ~bus.req_accept;

    if (resp_fire) begin
      if (tbl_valid_q[bus.resp_id] && tbl_vdc_q[bus.resp_id]) begin
        pend_d[vrf_waddr] = 1'b0;
        vrf_we            = bus.resp_vd_write;
      end
      tbl_valid_d[bus.resp_id] = 1'b0;
      if (bus.resp_rd_write) begin
        wb_valid_d = 1'b1;
        wb_id_d    = bus.resp_id;
        wb_rd_d    = bus.resp_rd;
      end
    end

    if (issue_fire && bus.req_accept && (bus.req_vd_clobber || bus.req_rd_clobber)) begin
      tbl_valid_d[in_id] = 1'b1;
      tbl_vdc_d[in_id]   = bus.req_vd_clobber;
      tbl_rdc_d[in_id]   = bus.req_rd_clobber;
      tbl_vd_d[in_id]    = vd;
      if (bus.req_vd_clobber) pend_d[vd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q      <= '0;
      tbl_valid_q <= '0;
      tbl_vdc_q   <= '0;
      tbl_rdc_q   <= '0;
      for (int i = 0; i < NoIds; i++) tbl_vd_q[i] <= '0;
      wb_valid_q  <= 1'b0;
      wb_id_q     <= '0;
      wb_rd_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      tbl_valid_q <= tbl_valid_d;
      tbl_vdc_q   <= tbl_vdc_d;
      tbl_rdc_q   <= tbl_rdc_d;
      tbl_vd_q    <= tbl_vd_d;
      wb_valid_q  <= wb_valid_d;
      wb_id_q     <= wb_id_d;
      wb_rd_q     <= wb_rd_d;
      illegal_q   <= illegal_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NoVRegs; i++) vrf_q[i] <= '0;
    end else if (vrf_we) begin
      vrf_q[vrf_waddr] <= bus.resp_vd;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_id    = wb_id_q;
  assign wb_rd    = wb_rd_q;
  assign illegal  = illegal_q;

  // Scalar operand usage and rd_clobber have no effect on hazards here.
  logic unused_sigs;
  assign unused_sigs = ^{bus.req_rs1_read, bus.req_rs2_read, tbl_rdc_q};

endmodule

// File: tb/tb_xadac_issue_stage.sv
// Bench for xadac_issue_stage: directed scenarios then random traffic, checked against
// a model that tracks the set of outstanding transactions as a queue of records.
module tb_xadac_issue_stage;

  localparam int unsigned IdWidth = 4;
  localparam int unsigned XLen    = 32;
  localparam int unsigned VLen    = 64;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic               in_ready;
  logic [IdWidth-1:0] in_id;
  logic [31:0]        in_instr;
  logic [XLen-1:0]    in_rs1, in_rs2;
  logic               wb_valid;
  logic [IdWidth-1:0] wb_id;
  logic [XLen-1:0]    wb_rd;
  logic               illegal;

  xadac_issue_stage_if #(.IdWidth(IdWidth), .XLen(XLen), .VLen(VLen)) bus ();

  xadac_issue_stage #(.IdWidth(IdWidth), .XLen(XLen), .VLen(VLen), .NoVRegs(32)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_id    (in_id),
    .in_instr (in_instr),
    .in_rs1   (in_rs1),
    .in_rs2   (in_rs2),
    .bus      (bus),
    .wb_valid (wb_valid),
    .wb_id    (wb_id),
    .wb_rd    (wb_rd),
    .illegal  (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: VRF contents plus the list of in-flight transactions that hold an ID.
  typedef struct {
    logic [IdWidth-1:0] id;
    logic [4:0]         vd;
    logic               vdc;
  } rec_t;

  logic [VLen-1:0]    mvrf [32];
  rec_t               outq [$];
  logic               exp_wb_valid, exp_illegal;
  logic [IdWidth-1:0] exp_wb_id;
  logic [XLen-1:0]    exp_wb_rd;
  logic               last_consumed;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic reg_pending(input logic [4:0] r);
    foreach (outq[i]) if (outq[i].vdc && outq[i].vd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic id_busy(input logic [IdWidth-1:0] id);
    foreach (outq[i]) if (outq[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_stall();
    return (bus.req_vs1_read && reg_pending(in_instr[19:15])) ||
           (bus.req_vs2_read && reg_pending(in_instr[24:20])) ||
           ((bus.req_vs3_read || bus.req_vd_clobber) && reg_pending(in_instr[11:7])) ||
           id_busy(in_id);
  endfunction

  task automatic m_reset();
    outq.delete();
    for (int i = 0; i < 32; i++) mvrf[i] = '0;
    exp_wb_valid = 1'b0;
    exp_wb_id    = '0;
    exp_wb_rd    = '0;
    exp_illegal  = 1'b0;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick();
    logic exp_rv, issue;
    int   idx;
    #1;
    if (!rstn) m_reset();
    exp_rv = rstn && in_valid && !m_stall();
    check("req_valid", bus.req_valid, exp_rv);
    check("in_ready", in_ready, exp_rv && bus.req_ready);
    check("resp_ready", bus.resp_ready, rstn);
    check("req_id", bus.req_id, in_id);
    check("req_instr", bus.req_instr, in_instr);
    check("req_rs1", bus.req_rs1, in_rs1);
    check("req_rs2", bus.req_rs2, in_rs2);
    check("req_vs1", bus.req_vs1, mvrf[in_instr[19:15]]);
    check("req_vs2", bus.req_vs2, mvrf[in_instr[24:20]]);
    check("req_vs3", bus.req_vs3, mvrf[in_instr[11:7]]);
    check("wb_valid", wb_valid, exp_wb_valid);
    check("wb_id", wb_id, exp_wb_id);
    check("wb_rd", wb_rd, exp_wb_rd);
    check("illegal", illegal, exp_illegal);

    issue = exp_rv && bus.req_ready;
    if (rstn) begin
      exp_wb_valid = bus.resp_valid && bus.resp_rd_write;
      if (bus.resp_valid) begin
        idx = -1;
        foreach (outq[i]) if (outq[i].id == bus.resp_id) idx = i;
        if (idx >= 0) begin
          if (outq[idx].vdc && bus.resp_vd_write) mvrf[outq[idx].vd] = bus.resp_vd;
          outq.delete(idx);
        end
        if (bus.resp_rd_write) begin
          exp_wb_id = bus.resp_id;
          exp_wb_rd = bus.resp_rd;
        end
      end
      exp_illegal = issue && !bus.req_accept;
      if (issue && bus.req_accept && (bus.req_vd_clobber || bus.req_rd_clobber))
        outq.push_back('{id: in_id, vd: in_instr[11:7], vdc: bus.req_vd_clobber});
    end
    last_consumed = issue;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [IdWidth-1:0] id, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d, input logic [2:0] rd3, input logic vdc,
                       input logic rdc, input logic acc);
    logic [31:0] w;
    w = $urandom;
    w[19:15] = s1;
    w[24:20] = s2;
    w[11:7]  = d;
    in_id    = id;
    in_instr = w;
    in_rs1   = $urandom;
    in_rs2   = $urandom;
    bus.req_rs1_read   = 1'($urandom_range(0, 1));
    bus.req_rs2_read   = 1'($urandom_range(0, 1));
    bus.req_vs1_read   = rd3[0];
    bus.req_vs2_read   = rd3[1];
    bus.req_vs3_read   = rd3[2];
    bus.req_vd_clobber = vdc;
    bus.req_rd_clobber = rdc;
    bus.req_accept     = acc;
  endtask

  task automatic respond(input logic v, input logic [IdWidth-1:0] id, input logic rdw,
                         input logic [XLen-1:0] rd, input logic vdw, input logic [VLen-1:0] vdat);
    bus.resp_valid    = v;
    bus.resp_id       = id;
    bus.resp_rd_write = rdw;
    bus.resp_rd       = rd;
    bus.resp_vd_write = vdw;
    bus.resp_vd       = vdat;
  endtask

  initial begin
    rstn = 1'b1;
    in_valid = 1'b0;
    bus.req_ready = 1'b0;
    drive(0, 0, 0, 0, 3'b000, 1'b0, 1'b0, 1'b1);
    respond(1'b0, 0, 1'b0, '0, 1'b0, '0);
    m_reset();
    last_consumed = 1'b0;
    #1 rstn = 1'b0;
    @(negedge clk);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // vload to v3 with id 2, then RAW reader of v3 stalls until the retire lands
    bus.req_ready = 1'b1;
    drive(2, 0, 0, 3, 3'b000, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    drive(4, 3, 0, 8, 3'b001, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b1;
    #1 check("raw_stall", bus.req_valid, 1'b0);
    tick();
    respond(1'b1, 2, 1'b0, '0, 1'b1, 64'hA5A5);
    tick();
    respond(1'b0, 0, 1'b0, '0, 1'b0, '0);
    #1 check("raw_unblock", bus.req_valid, 1'b1);
    check("raw_vs1_new", bus.req_vs1, 64'hA5A5);
    tick();

    // WAW on v3 and reuse of an outstanding id
    drive(2, 0, 0, 3, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(6, 0, 0, 3, 3'b000, 1'b1, 1'b0, 1'b1);
    #1 check("waw_stall", bus.req_valid, 1'b0);
    tick();
    drive(2, 1, 1, 9, 3'b000, 1'b1, 1'b0, 1'b1);
    #1 check("id_stall", bus.req_valid, 1'b0);
    tick();
    respond(1'b1, 2, 1'b0, '0, 1'b0, 64'hDEAD);
    tick();
    respond(1'b0, 0, 1'b0, '0, 1'b0, '0);
    #1 check("id_unblock", bus.req_valid, 1'b1);
    tick();
    drive(6, 0, 3, 3, 3'b010, 1'b1, 1'b0, 1'b1);
    #1 check("vrf_kept_no_vdw", bus.req_vs2, 64'hA5A5);
    tick();
    in_valid = 1'b0;
    respond(1'b1, 2, 1'b0, '0, 1'b1, 64'h77);
    tick();
    respond(1'b1, 6, 1'b0, '0, 1'b1, 64'h66);
    tick();
    respond(1'b1, 4, 1'b1, 32'h44, 1'b0, '0);
    tick();
    respond(1'b0, 0, 1'b0, '0, 1'b0, '0);

    // unrecognised instruction: consumed, illegal pulse, no hazard recorded
    drive(7, 0, 0, 10, 3'b000, 1'b1, 1'b1, 1'b0);
    in_valid = 1'b1;
    #1 check("illegal_in_ready", in_ready, 1'b1);
    tick();
    drive(7, 10, 10, 10, 3'b111, 1'b1, 1'b0, 1'b1);
    #1 check("illegal_pulse", illegal, 1'b1);
    check("illegal_no_stall", bus.req_valid, 1'b1);
    tick();
    in_valid = 1'b0;
    #1 check("illegal_once", illegal, 1'b0);
    respond(1'b1, 7, 1'b0, '0, 1'b1, 64'h10);
    tick();

    // scalar writeback with no table entry
    respond(1'b1, 5, 1'b1, 32'h1234, 1'b0, '0);
    tick();
    respond(1'b0, 0, 1'b0, '0, 1'b0, '0);
    #1 check("wb_pulse_valid", wb_valid, 1'b1);
    check("wb_pulse_id", wb_id, 5);
    check("wb_pulse_rd", wb_rd, 32'h1234);
    tick();

    // reset with three outstanding writers and a stalled reader
    in_valid = 1'b1;
    drive(1, 0, 0, 4, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(9, 0, 0, 5, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(11, 0, 0, 6, 3'b000, 1'b1, 1'b0, 1'b1);
    tick();
    drive(3, 4, 5, 6, 3'b011, 1'b0, 1'b1, 1'b1);
    tick();
    rstn = 1'b0;
    #1 check("rst_vrf_cleared", bus.req_vs3, 64'h0);
    tick();
    rstn = 1'b1;
    #1 check("post_reset_issue", bus.req_valid, 1'b1);
    tick();
    in_valid = 1'b0;
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      if (!in_valid || last_consumed) begin
        drive(IdWidth'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'($urandom_range(0, 7)), 3'($urandom), 1'($urandom), 1'($urandom),
              $urandom_range(0, 9) != 0);
        in_valid = $urandom_range(0, 3) != 0;
      end
      bus.req_ready = $urandom_range(0, 3) != 0;
      respond($urandom_range(0, 1) == 1,
              (outq.size() > 0 && $urandom_range(0, 3) != 0) ?
                outq[$urandom_range(0, outq.size() - 1)].id : IdWidth'($urandom),
              1'($urandom), $urandom, 1'($urandom), {$urandom, $urandom});
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
